// File: rtl/jpeg_stream_fifo.sv
// Synchronous FWFT FIFO for JPEG pipeline words with occupancy, thresholds, flush and sticky errors.
// Optional peak-occupancy tracking is enabled by defining FIFO_HWM_EN.
module jpeg_stream_fifo #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2,
   localparam int ADDR_W  = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              img_rst,
   input  logic              flush,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rd_ready,
   output logic [CNT_W-1:0]  count,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow,
   output logic [CNT_W-1:0]  hwm
);

   localparam logic [ADDR_W:0]  PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [CNT_W-1:0]  count_nxt;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   // Extra pointer MSB distinguishes full from empty when the indices coincide.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

   assign push = wr_valid & ~full;
   assign pop  = rd_ready & ~empty;

   assign wr_ready     = ~full;
   assign rd_valid     = ~empty;
   assign rd_data      = mem[rd_ptr[ADDR_W-1:0]];
   assign almost_full  = (count >= CNT_W'(AF_LEVEL));
   assign almost_empty = (count <= CNT_W'(AE_LEVEL));

   always_comb begin
      count_nxt = count;
      if (img_rst || flush) begin
         count_nxt = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (img_rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_valid && full)
            overflow <= 1'b1;
         if (rd_ready && empty)
            underflow <= 1'b1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
               rd_ptr <= rd_ptr + PTR_ONE;
         end
         count <= count_nxt;
      end
   end

   // Storage is deliberately left without reset; rd_data is only meaningful with rd_valid.
   always_ff @(posedge clk) begin
      if (push && !flush && !img_rst)
         mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
   end

`ifdef FIFO_HWM_EN
   always_ff @(posedge clk) begin
      if (img_rst)
         hwm <= '0;
      else if (count_nxt > hwm)
         hwm <= count_nxt;
   end
`else
   assign hwm = '0;
`endif

endmodule
